// File: rtl/rand_arbiter_if.sv
// Handshake bundle between the random-byte arbiter and its requesters.
// The arbiter uses the slave view; requesters or a bench use the master view.
interface rand_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [7:0]       i_sed;
  logic             i_sed_load;
  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic             o_valid;
  logic [7:0]       o_rand;
  logic             o_busy;

  modport slave (
    input  i_sed, i_sed_load, i_req,
    output o_gnt, o_valid, o_rand, o_busy
  );

  modport master (
    output i_sed, i_sed_load, i_req,
    input  o_gnt, o_valid, o_rand, o_busy
  );
endinterface

// File: rtl/rand_arbiter.sv
// Shares one 8-bit Fibonacci LFSR among N_REQ requesters: serial MSB-first seed load,
// then round-robin grants, each carrying the LFSR value before that edge's advance.
module rand_arbiter #(
  parameter int          N_REQ        = 4,
  parameter logic [7:0]  SEED_DEFAULT = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  rand_arbiter_if.slave   bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       seed_q, seed_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [7:0]       rand_q, rand_d;
  logic [IDX_W-1:0] pick;

  // x^8+x^6+x^5+x^4+1, taps 7/5/4/3
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // All-zero would lock the LFSR up, so it is replaced by 1.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // First asserted requester at or after start, scanning upward with wrap.
  // Scanning offsets from high to low lets the smallest offset win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] k;
    int               idx;
    k = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % N_REQ;
      if (req[idx]) k = IDX_W'(idx);
    end
    return k;
  endfunction

  assign pick = rr_pick(bus.i_req, ptr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    rand_d  = rand_q;

    case (state_q)
      ST_LOAD: begin
        lfsr_d = {lfsr_q[6:0], seed_q[3'd7 - cnt_q]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (|bus.i_req) begin
          gnt_d[pick] = 1'b1;
          valid_d     = 1'b1;
          rand_d      = lfsr_q;
          ptr_d       = IDX_W'((int'(pick) + 1) % N_REQ);
        end
      end
    endcase

    // Reseed wins over a same-cycle grant; the request simply stays pending.
    if (bus.i_sed_load) begin
      seed_d  = seed_fix(bus.i_sed);
      state_d = ST_LOAD;
      cnt_d   = 3'd0;
      gnt_d   = '0;
      valid_d = 1'b0;
      rand_d  = rand_q;
      ptr_d   = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= 3'd0;
      seed_q  <= SEED_DEFAULT;
      lfsr_q  <= 8'h00;
      ptr_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      rand_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      rand_q  <= rand_d;
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_valid = valid_q;
  assign bus.o_rand  = rand_q;
  assign bus.o_busy  = (state_q == ST_LOAD);
endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: directed vector table, hand-written reseed/reset sequences,
// and randomized traffic against a behavioural model.
module tb_rand_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rand_arbiter_if #(.N_REQ(N)) bus ();

  rand_arbiter #(.N_REQ(N), .SEED_DEFAULT(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         ld;
    logic [7:0]   sed;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         vld;
    logic [7:0]   rnd;
    logic         busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic ld, input logic [7:0] sed, input logic [N-1:0] req,
                     input logic [N-1:0] gnt, input logic vld, input logic [7:0] rnd, input logic busy);
    vec_t v;
    v.rst = r; v.ld = ld; v.sed = sed; v.req = req;
    v.gnt = gnt; v.vld = vld; v.rnd = rnd; v.busy = busy;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] sed, input logic [N-1:0] req);
    bus.i_sed_load = ld;
    bus.i_sed      = sed;
    bus.i_req      = req;
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] gnt, input logic vld,
                         input logic [7:0] rnd, input logic busy);
    chk({tag, ".gnt"},   32'(bus.o_gnt),   32'(gnt));
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(vld));
    chk({tag, ".rand"},  32'(bus.o_rand),  32'(rnd));
    chk({tag, ".busy"},  32'(bus.o_busy),  32'(busy));
  endtask

  // Synchronous-style reset pulse across one edge, then the default load begins.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_busy_left;
  int           m_ptr;
  logic [7:0]   m_seed, m_cur, m_rand;
  logic [N-1:0] m_gnt;
  logic         m_vld;

  function automatic logic [7:0] step8(input logic [7:0] v);
    logic [7:0] t;
    t = v & 8'hB8;
    return 8'((int'(v) * 2) % 256 + int'(^t));
  endfunction

  task automatic model_reset();
    m_busy_left = 8; m_ptr = 0; m_seed = 8'hA5; m_cur = 8'h00;
    m_rand = 8'h00; m_gnt = '0; m_vld = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [7:0] sed, input logic [N-1:0] req);
    bit found;
    m_gnt = '0;
    m_vld = 1'b0;
    if (ld) begin
      m_seed      = (sed == 8'h00) ? 8'h01 : sed;
      m_busy_left = 8;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_cur = m_seed;
    end else begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (!found && req[j]) begin
          found  = 1;
          m_gnt  = N'(1) << j;
          m_vld  = 1'b1;
          m_rand = m_cur;
          m_ptr  = (j + 1) % N;
        end
      end
      m_cur = step8(m_cur);
    end
  endtask

  initial begin
    logic [7:0]   prev_rand;
    logic         prev_vld;
    logic [N-1:0] rq;
    logic         ld;
    logic [7:0]   sd;

    drive(1'b0, 8'h00, '0);

    // Test 1: default seed, req0 held
    add(1, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h00, 1);
    repeat (7) add(0, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h00, 1);
    add(0, 0, 8'h00, 4'b0001, 4'b0000, 0, 8'h00, 0);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 8'hA5, 0);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 8'h4A, 0);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 8'h95, 0);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 8'h2A, 0);
    // Test 2: all requesting, round-robin rotation
    add(1, 0, 8'h00, 4'b1111, 4'b0000, 0, 8'h00, 1);
    repeat (7) add(0, 0, 8'h00, 4'b1111, 4'b0000, 0, 8'h00, 1);
    add(0, 0, 8'h00, 4'b1111, 4'b0000, 0, 8'h00, 0);
    add(0, 0, 8'h00, 4'b1111, 4'b0001, 1, 8'hA5, 0);
    add(0, 0, 8'h00, 4'b1111, 4'b0010, 1, 8'h4A, 0);
    add(0, 0, 8'h00, 4'b1111, 4'b0100, 1, 8'h95, 0);
    add(0, 0, 8'h00, 4'b1111, 4'b1000, 1, 8'h2A, 0);
    add(0, 0, 8'h00, 4'b1111, 4'b0001, 1, 8'h54, 0);
    // Test 3: zero seed is substituted with 01; o_rand holds during load
    add(0, 1, 8'h00, 4'b0000, 4'b0000, 0, 8'h54, 1);
    repeat (7) add(0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h54, 1);
    add(0, 0, 8'h00, 4'b0000, 4'b0000, 0, 8'h54, 0);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 8'h01, 0);
    add(0, 0, 8'h00, 4'b0001, 4'b0001, 1, 8'h02, 0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      drive(tbl[i].ld, tbl[i].sed, tbl[i].req);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].vld, tbl[i].rnd, tbl[i].busy);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, '0);

    // Test 4: reseed beats a same-cycle request, which is granted after load
    do_reset();
    repeat (8) tick();
    drive(1'b1, 8'h77, 4'b0100);
    tick();
    chk_all("t4.reseed", 4'b0000, 0, 8'h00, 1);
    drive(1'b0, 8'h00, 4'b0100);
    repeat (7) tick();
    chk("t4.busy7", 32'(bus.o_busy), 32'd1);
    tick();
    chk_all("t4.loaded", 4'b0000, 0, 8'h00, 0);
    tick();
    chk_all("t4.grant", 4'b0100, 1, 8'h77, 0);

    // Test 5: reseed during LOAD restarts the load
    drive(1'b0, 8'h00, '0);
    do_reset();
    repeat (3) tick();
    drive(1'b1, 8'h3C, '0);
    tick();
    chk("t5.busy_restart", 32'(bus.o_busy), 32'd1);
    drive(1'b0, 8'h00, '0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t5.busy%0d", i), 32'(bus.o_busy), 32'd1);
    end
    tick();
    chk("t5.done", 32'(bus.o_busy), 32'd0);
    drive(1'b0, 8'h00, 4'b0001);
    tick();
    chk_all("t5.first", 4'b0001, 1, 8'h3C, 0);

    // Test 6: asynchronous reset mid-RUN while a grant is showing
    drive(1'b0, 8'h00, 4'b0001);
    tick();
    chk("t6.pre_valid", 32'(bus.o_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_all("t6.async", 4'b0000, 0, 8'h00, 1);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    tick();
    chk_all("t6.restart", 4'b0001, 1, 8'hA5, 0);

    // Randomized traffic against the model
    drive(1'b0, 8'h00, '0);
    do_reset();
    model_reset();
    prev_vld  = 1'b0;
    prev_rand = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      rq = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom_range(0, 15));
      ld = ($urandom_range(0, 59) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      drive(ld, sd, rq);
      model_edge(ld, sd, rq);
      tick();
      chk_all($sformatf("rnd%0d", c), m_gnt, m_vld, m_rand, (m_busy_left > 0));
      if (bus.o_valid && prev_vld)
        chk($sformatf("rnd%0d.distinct", c), 32'(bus.o_rand != prev_rand), 32'd1);
      prev_vld  = bus.o_valid;
      prev_rand = bus.o_rand;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
